disp_queue_sched: RTL and testbench
===================================

DISP_QUEUE_SCHED -- requirements
Module: disp_queue_sched

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of queue entries; only powers of two from 2 to 16 are legal.
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 25000000, giving the display hold time per byte in clock cycles; the legal minimum is 2.
REQ-003 The module SHALL have port i_clk  input  1  system clock; all logic is on the rising edge.
REQ-004 The module SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port i_rx_dv  input  1  single-cycle strobe that marks i_rx_byte valid.
REQ-006 The module SHALL have port i_rx_byte  input  8  received data byte.
REQ-007 The module SHALL have port i_pause  input  1  level input; while high, it freezes the hold timer and any dequeue.
REQ-008 The module SHALL have port i_clear  input  1  level input; while high, it flushes the queue and blanks the display.
REQ-009 The module SHALL have port o_disp_byte  output  8  byte presented to the 7-segment decoder.
REQ-010 The module SHALL have port o_showing  output  1  high while in state SHOW.
REQ-011 The module SHALL have port o_level  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-012 The module SHALL have port o_overflow  output  1  sticky flag for a dropped byte.

Function
REQ-013 The module SHALL hold bytes in a FIFO of DEPTH entries, using read and write pointers that wrap modulo DEPTH.
REQ-014 A high i_rx_dv with o_level < DEPTH SHALL write i_rx_byte and increment o_level at that clock edge.
REQ-015 A high i_rx_dv with o_level == DEPTH and no pop on the same edge SHALL drop the byte, set o_overflow, and leave the queue contents unchanged.
REQ-016 When the queue is full, a push and a pop on the same edge SHALL both complete; o_level stays DEPTH and o_overflow is not set.
REQ-017 When the queue is empty, a push and a pop SHALL NOT occur on the same edge, because a pop requires o_level > 0 in the cycle before the edge.
REQ-018 The FSM SHALL have the states IDLE, LOAD and SHOW.
REQ-019 IDLE SHALL go to LOAD when o_level > 0 and i_pause == 0; otherwise the FSM remains in IDLE.
REQ-020 LOAD SHALL last exactly one cycle: it pops the head entry into o_disp_byte, loads the hold counter with 0, and moves to SHOW.
REQ-021 In SHOW, the hold counter SHALL increment each cycle while i_pause == 0 and hold its value while i_pause == 1.
REQ-022 SHOW SHALL exit when the counter reaches HOLD_CYCLES-1 and i_pause == 0: it goes to LOAD if o_level > 0, else to IDLE.
REQ-023 Each dequeued byte SHALL therefore be displayed for exactly HOLD_CYCLES+1 unpaused cycles, counting LOAD plus SHOW.
REQ-024 In IDLE, o_disp_byte SHALL keep the last displayed byte.
REQ-025 Latency: with the FSM in IDLE, the queue empty and i_pause low, a byte sampled at edge N SHALL appear on o_disp_byte after edge N+2.
REQ-026 i_pause SHALL NOT block enqueue.
REQ-027 i_clear SHALL take priority over every other input.
REQ-028 While i_clear is high, on each edge the module SHALL:
- reset both pointers and o_level to 0;
- set o_disp_byte to 0x00 and o_overflow to 0;
- clear the hold counter;
- force the FSM to IDLE;
- ignore i_rx_dv.
REQ-029 o_overflow SHALL clear only on i_clear or reset.
REQ-030 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-031 The hold counter SHALL be $clog2(HOLD_CYCLES) bits wide and SHALL never wrap past HOLD_CYCLES-1.

Reset
REQ-032 While i_rst_n is low, the module SHALL asynchronously force FSM=IDLE, pointers=0, counter=0, o_disp_byte=0x00, o_showing=0, o_level=0, o_overflow=0.
REQ-033 Reset asserted mid-SHOW or mid-LOAD SHALL discard all queued bytes; no partial state survives.
REQ-034 After i_rst_n deasserts, the module SHALL act on the first rising edge, and the first i_rx_dv on that edge SHALL be accepted.

Verification (bench settings: DEPTH=4, HOLD_CYCLES=4)
REQ-035 Single byte: strobe 0x3A at edge N -> o_disp_byte=0x3A after edge N+2; o_showing high for 4 cycles; the FSM then returns to IDLE with 0x3A held.
REQ-036 Burst and overflow: 6 back-to-back strobes 0x01..0x06 while paused -> o_level=4, o_overflow=1, bytes 0x05 and 0x06 lost; unpause -> the display shows 0x01,0x02,0x03,0x04, each for 5 cycles, with no gap.
REQ-037 Full push-pop: queue full and the FSM in LOAD while a strobe of 0x77 arrives -> o_level stays 4; 0x77 is later displayed; o_overflow stays 0.
REQ-038 Pause mid-hold: pause for 10 cycles starting at counter value 2 -> the byte is shown 10 cycles longer; no pop occurs during the pause.
REQ-039 Clear with 3 entries queued, 0x55 shown and o_overflow=1 -> the next edge gives o_level=0, o_disp_byte=0x00, o_overflow=0, IDLE; a strobe during clear is ignored.
REQ-040 Reset mid-SHOW with 2 entries queued -> all outputs are immediately at their REQ-032 values; after release, a new strobe of 0x9C displays 0x9C after edge N+2.

Source files
------------

// File: rtl/disp_queue_sched.sv
// Byte queue feeding a 7-segment display: each dequeued byte is held for a
// fixed number of clock cycles, with pause, flush and sticky overflow.
module disp_queue_sched #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rx_dv,
  input  logic [7:0]               i_rx_byte,
  input  logic                     i_pause,
  input  logic                     i_clear,
  output logic [7:0]               o_disp_byte,
  output logic                     o_showing,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

  state_t        state;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] hold_cnt;
  logic [7:0]    mem [DEPTH];

  logic full;
  logic pop;
  logic push;

  // NOTE: always_comb with '=' only; every signal gets a value on every pass so no latch is inferred.
  always_comb begin
    full = (o_level == LEVEL_FULL);
    pop  = (state == LOAD) && !i_pause && (o_level != '0);
    // A full queue still accepts a byte when the head leaves on the same edge.
    push = i_rx_dv && (!full || pop);
  end

  // NOTE: the storage array has no reset; pointers and level define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push && !i_clear) mem[wr_ptr] <= i_rx_byte;
  end

  // NOTE: sequential state uses '<=' so every register samples pre-edge values (e.g. mem[rd_ptr] during a full push+pop).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      hold_cnt    <= '0;
      o_disp_byte <= 8'h00;
      o_showing   <= 1'b0;
      o_level     <= '0;
      o_overflow  <= 1'b0;
    end else if (i_clear) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      hold_cnt    <= '0;
      o_disp_byte <= 8'h00;
      o_showing   <= 1'b0;
      o_level     <= '0;
      o_overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (push && !pop)      o_level <= o_level + (AW+1)'(1);
      else if (pop && !push) o_level <= o_level - (AW+1)'(1);

      if (i_rx_dv && full && !pop) o_overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (o_level != '0 && !i_pause) state <= LOAD;
        end
        LOAD: begin
          if (pop) begin
            o_disp_byte <= mem[rd_ptr];
            hold_cnt    <= '0;
            o_showing   <= 1'b1;
            state       <= SHOW;
          end
        end
        SHOW: begin
          if (!i_pause) begin
            // Counter parks at its last value on exit so it can never wrap.
            if (hold_cnt == HOLD_LAST) begin
              o_showing <= 1'b0;
              state     <= (o_level != '0) ? LOAD : IDLE;
            end else begin
              hold_cnt <= hold_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_queue_sched.sv
// Directed bench for disp_queue_sched with DEPTH=4, HOLD_CYCLES=4; outputs
// are sampled 1 ns after each rising edge.
module tb_disp_queue_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       pause;
  logic       clear;
  logic [7:0] disp_byte;
  logic       showing;
  logic [2:0] level;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;

  disp_queue_sched #(.DEPTH(4), .HOLD_CYCLES(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_dv     (rx_dv),
    .i_rx_byte   (rx_byte),
    .i_pause     (pause),
    .i_clear     (clear),
    .o_disp_byte (disp_byte),
    .o_showing   (showing),
    .o_level     (level),
    .o_overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_disp"},     32'(disp_byte), 32'h00);
    check({tag, "_showing"},  32'(showing),   32'h0);
    check({tag, "_level"},    32'(level),     32'h0);
    check({tag, "_overflow"}, 32'(overflow),  32'h0);
  endtask

  initial begin
    logic [7:0] exp_byte;

    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; pause = 1'b0; clear = 1'b0;
    #1;
    check_all_zero("reset");
    tick(); tick();

    // Single byte, strobed on the very first edge after reset release
    rst_n = 1'b1; rx_dv = 1'b1; rx_byte = 8'h3A;
    tick();
    rx_dv = 1'b0;
    check("single_level_n", 32'(level), 32'd1);
    tick();
    check("single_disp_n1", 32'(disp_byte), 32'h00);
    tick();
    check("single_disp_n2", 32'(disp_byte), 32'h3A);
    check("single_show_n2", 32'(showing), 32'h1);
    check("single_level_n2", 32'(level), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("single_show_%0d", i + 3), 32'(showing), 32'h1);
    end
    tick();
    check("single_show_off", 32'(showing), 32'h0);
    tick(); tick();
    check("single_held", 32'(disp_byte), 32'h3A);

    // Burst of six while paused: four stored, two dropped
    pause = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      rx_dv = 1'b1; rx_byte = 8'(i);
      tick();
    end
    rx_dv = 1'b0;
    check("burst_level", 32'(level), 32'd4);
    check("burst_overflow", 32'(overflow), 32'h1);
    check("burst_idle", 32'(showing), 32'h0);
    pause = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 1)       exp_byte = 8'h3A;
      else if (k <= 21) exp_byte = 8'((k - 2) / 5 + 1);
      else              exp_byte = 8'h04;
      check($sformatf("burst_disp_%0d", k), 32'(disp_byte), 32'(exp_byte));
    end
    check("burst_end_level", 32'(level), 32'd0);
    check("burst_end_show", 32'(showing), 32'h0);
    check("burst_sticky", 32'(overflow), 32'h1);

    // Flush to drop the sticky flag, then full push+pop while in LOAD
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_all_zero("pre_fpp_clear");
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_dv = 1'b1; rx_byte = 8'hA1 + 8'(i);
      tick();
    end
    rx_dv = 1'b0; pause = 1'b0;
    check("fpp_full", 32'(level), 32'd4);
    tick();
    check("fpp_load_level", 32'(level), 32'd4);
    rx_dv = 1'b1; rx_byte = 8'h77;
    tick();
    rx_dv = 1'b0;
    check("fpp_level", 32'(level), 32'd4);
    check("fpp_overflow", 32'(overflow), 32'h0);
    check("fpp_disp_a1", 32'(disp_byte), 32'hA1);
    for (int i = 0; i < 19; i++) tick();
    check("fpp_disp_a4", 32'(disp_byte), 32'hA4);
    tick();
    check("fpp_disp_77", 32'(disp_byte), 32'h77);
    for (int i = 0; i < 4; i++) tick();
    check("fpp_idle", 32'(showing), 32'h0);
    check("fpp_overflow_end", 32'(overflow), 32'h0);

    // Pause for 10 cycles starting at counter value 2
    rx_dv = 1'b1; rx_byte = 8'h42;
    tick();
    rx_byte = 8'h43;
    tick();
    rx_dv = 1'b0;
    check("pause_level_q", 32'(level), 32'd2);
    tick();
    check("pause_disp_42", 32'(disp_byte), 32'h42);
    tick(); tick();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("pause_hold_lvl_%0d", i), 32'(level), 32'd1);
      check($sformatf("pause_hold_shw_%0d", i), 32'(showing), 32'h1);
    end
    pause = 1'b0;
    tick();
    check("pause_last_show", 32'(showing), 32'h1);
    tick();
    check("pause_load_disp", 32'(disp_byte), 32'h42);
    check("pause_load_show", 32'(showing), 32'h0);
    tick();
    check("pause_disp_43", 32'(disp_byte), 32'h43);
    for (int i = 0; i < 4; i++) tick();
    check("pause_idle", 32'(showing), 32'h0);

    // Clear with three queued, 0x55 on display and overflow set
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_dv = 1'b1; rx_byte = (i == 0) ? 8'h55 : 8'hB0 + 8'(i);
      tick();
    end
    rx_dv = 1'b0; pause = 1'b0;
    tick(); tick();
    check("clr_pre_disp", 32'(disp_byte), 32'h55);
    check("clr_pre_level", 32'(level), 32'd3);
    check("clr_pre_ovf", 32'(overflow), 32'h1);
    clear = 1'b1; rx_dv = 1'b1; rx_byte = 8'hEE;
    tick();
    check_all_zero("clear");
    tick();
    check("clear_ignore_dv", 32'(level), 32'd0);
    clear = 1'b0; rx_dv = 1'b0;
    tick(); tick(); tick();
    check("clear_stays_idle", 32'(disp_byte), 32'h00);
    check("clear_stays_show", 32'(showing), 32'h0);

    // Reset mid-SHOW with two entries queued
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_dv = 1'b1; rx_byte = 8'hC1 + 8'(i);
      tick();
    end
    rx_dv = 1'b0; pause = 1'b0;
    tick(); tick();
    check("rst_pre_disp", 32'(disp_byte), 32'hC1);
    check("rst_pre_level", 32'(level), 32'd2);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick(); tick();
    rst_n = 1'b1; rx_dv = 1'b1; rx_byte = 8'h9C;
    tick();
    rx_dv = 1'b0;
    check("post_rst_level", 32'(level), 32'd1);
    tick();
    check("post_rst_n1", 32'(disp_byte), 32'h00);
    tick();
    check("post_rst_disp", 32'(disp_byte), 32'h9C);
    check("post_rst_show", 32'(showing), 32'h1);
    check("post_rst_level0", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
